// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: lock-controller state encoding, PD direction
// encoding and default DCDL geometry.
package fmdll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAR    = 2'd1,
      ST_TRACK  = 2'd2,
      ST_LOCKED = 2'd3
   } lock_state_e;

   typedef enum logic {
      DIR_LAG  = 1'b0,
      DIR_LEAD = 1'b1
   } pd_dir_e;

   localparam int unsigned DEF_CW        = 6;
   localparam int unsigned DEF_FW        = 16;
   localparam int unsigned DEF_SETTLE    = 4;
   localparam int unsigned DEF_LOCK_CNT  = 8;
   localparam int unsigned DEF_UNLOCK_TH = 4;

   // Width of the fine count f, which spans 0..fw inclusive.
   function automatic int unsigned fcode_width(input int unsigned fw);
      return $clog2(fw + 1);
   endfunction

endpackage

// File: rtl/dcdl_lock_ctrl_if.sv
// Phase-detector decision inputs and DCDL code / status outputs of the lock controller.
interface dcdl_lock_ctrl_if
   import fmdll_pkg::*;
#(
   parameter int unsigned CW = DEF_CW,
   parameter int unsigned FW = DEF_FW
) ();

   logic          en;
   logic          pd_valid;
   logic          pd_lead;
   logic [CW-1:0] Q;
   logic [FW-1:0] T;
   logic [FW-1:0] Tb;
   logic          lock;
   logic          busy;
   logic          sat;

   modport master (
      output en, pd_valid, pd_lead,
      input  Q, T, Tb, lock, busy, sat
   );

   modport slave (
      input  en, pd_valid, pd_lead,
      output Q, T, Tb, lock, busy, sat
   );

endinterface

// File: rtl/dcdl_therm_enc.sv
// Fine-code encoder: count f (0..FW) to thermometer T = (1<<f)-1 and its complement Tb.
module dcdl_therm_enc
   import fmdll_pkg::*;
#(
   parameter int unsigned FW = DEF_FW
) (
   input  logic [fcode_width(FW)-1:0] f_i,
   output logic [FW-1:0]              t_o,
   output logic [FW-1:0]              tb_o
);

   always_comb begin
      t_o = '0;
      for (int unsigned k = 0; k < FW; k++) begin
         t_o[k] = (32'(f_i) > k);
      end
   end

   assign tb_o = ~t_o;

endmodule

// File: rtl/dcdl_lock_ctrl.sv
// DCDL lock controller: SAR search on the coarse code, then bang-bang fine
// tracking with reversal-count lock detection.
module dcdl_lock_ctrl
   import fmdll_pkg::*;
#(
   parameter int unsigned CW        = DEF_CW,
   parameter int unsigned FW        = DEF_FW,
   parameter int unsigned SETTLE    = DEF_SETTLE,
   parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
   parameter int unsigned UNLOCK_TH = DEF_UNLOCK_TH
) (
   input  logic            CLK_exit,
   input  logic            rst,
   dcdl_lock_ctrl_if.slave pd_if
);

   localparam int unsigned FCW = fcode_width(FW);
   localparam int unsigned SCW = $clog2(SETTLE + 1);
   localparam int unsigned IW  = (CW > 1) ? $clog2(CW) : 1;
   localparam int unsigned RCW = $clog2(LOCK_CNT + 1);
   localparam int unsigned UCW = $clog2(UNLOCK_TH + 1);

   localparam logic [CW-1:0]  Q_MAX  = '1;
   localparam logic [CW-1:0]  Q_MID  = {1'b1, {(CW-1){1'b0}}};
   localparam logic [CW-1:0]  Q_ONE  = CW'(1);
   localparam logic [FCW-1:0] F_FULL = FCW'(FW);
   localparam logic [FCW-1:0] F_MID  = FCW'(FW / 2);
   localparam logic [FCW-1:0] F_ONE  = FCW'(1);
   localparam logic [FCW-1:0] F_TOP  = FCW'(FW - 1);
   localparam logic [SCW-1:0] S_LOAD = SCW'(SETTLE);
   localparam logic [IW-1:0]  I_TOP  = IW'(CW - 1);
   localparam logic [RCW-1:0] R_LOCK = RCW'(LOCK_CNT);
   localparam logic [UCW-1:0] U_TH   = UCW'(UNLOCK_TH);

   lock_state_e    state_q;
   logic [CW-1:0]  q_q, q_d;
   logic [FCW-1:0] f_q, f_d;
   logic           sat_q, sat_d;
   logic [IW-1:0]  bit_q;
   logic           bit_set_q;
   logic [SCW-1:0] settle_q;
   pd_dir_e        prev_dir_q;
   logic           prev_vld_q;
   logic [RCW-1:0] rev_q, rev_d;
   logic [UCW-1:0] same_q, same_d;
   logic           lock_q, busy_q;
   pd_dir_e        pd_dir;

   assign pd_dir = pd_if.pd_lead ? DIR_LEAD : DIR_LAG;

   // One fine step with carry into / borrow from the coarse code.
   always_comb begin
      q_d   = q_q;
      f_d   = f_q;
      sat_d = sat_q;
      if (pd_dir == DIR_LEAD) begin
         if (f_q != F_FULL) begin
            f_d = f_q + F_ONE;
         end else if (q_q != Q_MAX) begin
            q_d = q_q + Q_ONE;
            f_d = F_ONE;
         end else begin
            sat_d = 1'b1;
         end
      end else begin
         if (f_q != '0) begin
            f_d = f_q - F_ONE;
         end else if (q_q != '0) begin
            q_d = q_q - Q_ONE;
            f_d = F_TOP;
         end else begin
            sat_d = 1'b1;
         end
      end
   end

   always_comb begin
      rev_d  = rev_q;
      same_d = same_q;
      if (prev_vld_q) begin
         if (pd_dir != prev_dir_q) begin
            if (rev_q != R_LOCK) rev_d = rev_q + RCW'(1);
            same_d = '0;
         end else begin
            rev_d = '0;
            if (same_q != U_TH) same_d = same_q + UCW'(1);
         end
      end
   end

   // Lock history restarts on SAR entry; SAR bit decisions do not feed it,
   // so the first tracking decision only seeds prev_dir.
   always_ff @(posedge CLK_exit) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         q_q        <= '0;
         f_q        <= '0;
         sat_q      <= 1'b0;
         bit_q      <= '0;
         bit_set_q  <= 1'b0;
         settle_q   <= '0;
         prev_dir_q <= DIR_LAG;
         prev_vld_q <= 1'b0;
         rev_q      <= '0;
         same_q     <= '0;
         lock_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else if (state_q != ST_IDLE && !pd_if.en) begin
         state_q   <= ST_IDLE;
         lock_q    <= 1'b0;
         busy_q    <= 1'b0;
         bit_set_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pd_if.en) begin
                  state_q    <= ST_SAR;
                  q_q        <= Q_MID;
                  f_q        <= F_MID;
                  bit_q      <= I_TOP;
                  bit_set_q  <= 1'b0;
                  settle_q   <= S_LOAD;
                  prev_vld_q <= 1'b0;
                  rev_q      <= '0;
                  same_q     <= '0;
                  sat_q      <= 1'b0;
                  lock_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_SAR: begin
               if (bit_set_q) begin
                  q_q[bit_q] <= 1'b1;
                  settle_q   <= S_LOAD;
                  bit_set_q  <= 1'b0;
               end else if (settle_q != '0) begin
                  settle_q <= settle_q - SCW'(1);
               end else if (pd_if.pd_valid) begin
                  if (!pd_if.pd_lead) q_q[bit_q] <= 1'b0;
                  if (bit_q != '0) begin
                     bit_q     <= bit_q - IW'(1);
                     bit_set_q <= 1'b1;
                  end else begin
                     state_q  <= ST_TRACK;
                     busy_q   <= 1'b0;
                     settle_q <= S_LOAD;
                  end
               end
            end
            default: begin
               if (settle_q != '0) begin
                  settle_q <= settle_q - SCW'(1);
               end else if (pd_if.pd_valid) begin
                  q_q        <= q_d;
                  f_q        <= f_d;
                  sat_q      <= sat_d;
                  settle_q   <= S_LOAD;
                  prev_dir_q <= pd_dir;
                  prev_vld_q <= 1'b1;
                  same_q     <= same_d;
                  rev_q      <= rev_d;
                  if (state_q == ST_TRACK && rev_d == R_LOCK) begin
                     state_q <= ST_LOCKED;
                     lock_q  <= 1'b1;
                  end else if (state_q == ST_LOCKED && same_d == U_TH) begin
                     state_q <= ST_TRACK;
                     lock_q  <= 1'b0;
                     rev_q   <= '0;
                  end
               end
            end
         endcase
      end
   end

   dcdl_therm_enc #(.FW(FW)) u_therm (
      .f_i  (f_q),
      .t_o  (pd_if.T),
      .tb_o (pd_if.Tb)
   );

   assign pd_if.Q    = q_q;
   assign pd_if.lock = lock_q;
   assign pd_if.busy = busy_q;
   assign pd_if.sat  = sat_q;

endmodule

// File: tb/tb_dcdl_lock_ctrl.sv
// Self-checking bench for dcdl_lock_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural lock-loop model.
module tb_dcdl_lock_ctrl;

   localparam int CW        = 6;
   localparam int FW        = 16;
   localparam int SETTLE    = 4;
   localparam int LOCK_CNT  = 8;
   localparam int UNLOCK_TH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcdl_lock_ctrl_if #(.CW(CW), .FW(FW)) bus ();

   dcdl_lock_ctrl #(
      .CW(CW), .FW(FW), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT), .UNLOCK_TH(UNLOCK_TH)
   ) dut (
      .CLK_exit (clk),
      .rst      (rst),
      .pd_if    (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: active/searching/locked flags, code as plain ints.
   bit m_on, m_srch, m_lk, m_pend, m_sat, m_hp, m_pd, m_acc;
   int m_q, m_f, m_bit, m_set, m_rev, m_same;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t: wait bound expired", nm, $time);
   endtask

   task automatic track_step(input bit lead);
      if (lead) begin
         if (m_f < FW) m_f++;
         else if (m_q < (1 << CW) - 1) begin m_q++; m_f = 1; end
         else m_sat = 1;
      end else begin
         if (m_f > 0) m_f--;
         else if (m_q > 0) begin m_q--; m_f = FW - 1; end
         else m_sat = 1;
      end
      m_set = SETTLE;
      if (m_hp) begin
         if (lead != m_pd) begin m_rev++; m_same = 0; end
         else begin m_rev = 0; m_same++; end
      end
      m_hp = 1;
      m_pd = lead;
      if (!m_lk && m_rev >= LOCK_CNT) m_lk = 1;
      else if (m_lk && m_same >= UNLOCK_TH) begin m_lk = 0; m_rev = 0; end
   endtask

   task automatic model();
      m_acc = 0;
      if (rst) begin
         m_on = 0; m_srch = 0; m_lk = 0; m_q = 0; m_f = 0; m_sat = 0;
         m_set = 0; m_pend = 0; m_hp = 0; m_pd = 0; m_rev = 0; m_same = 0; m_bit = 0;
      end else if (!m_on) begin
         if (bus.en) begin
            m_on = 1; m_srch = 1; m_lk = 0; m_q = 1 << (CW - 1); m_f = FW / 2;
            m_bit = CW - 1; m_pend = 0; m_set = SETTLE; m_sat = 0;
            m_hp = 0; m_rev = 0; m_same = 0;
         end
      end else if (!bus.en) begin
         m_on = 0; m_srch = 0; m_lk = 0; m_pend = 0;
      end else if (m_srch) begin
         if (m_pend) begin
            m_q = m_q | (1 << m_bit); m_set = SETTLE; m_pend = 0;
         end else if (m_set > 0) begin
            m_set--;
         end else if (bus.pd_valid) begin
            m_acc = 1;
            if (!bus.pd_lead) m_q = m_q & ~(1 << m_bit);
            if (m_bit > 0) begin m_bit--; m_pend = 1; end
            else begin m_srch = 0; m_set = SETTLE; end
         end
      end else if (m_set > 0) begin
         m_set--;
      end else if (bus.pd_valid) begin
         m_acc = 1;
         track_step(bus.pd_lead);
      end
   endtask

   task automatic check_all();
      logic [FW-1:0] et, etb;
      logic [CW-1:0] eq;
      et  = FW'((64'd1 << m_f) - 64'd1);
      etb = ~et;
      eq  = m_q[CW-1:0];
      check("Q", bus.Q, eq);
      check("T", bus.T, et);
      check("Tb", bus.Tb, etb);
      check("lock", bus.lock, m_lk);
      check("busy", bus.busy, m_srch);
      check("sat", bus.sat, m_sat);
   endtask

   task automatic step();
      model();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic decide(input bit lead);
      bit got;
      got = 0;
      bus.pd_valid = 1'b1;
      bus.pd_lead  = lead;
      for (int k = 0; k < 4 * SETTLE + 8 && !got; k++) begin
         step();
         got = m_acc;
      end
      bus.pd_valid = 1'b0;
      if (!got) timeout("decide_accept");
   endtask

   task automatic run_sar(input int target);
      bit done;
      done = 0;
      bus.pd_valid = 1'b0;
      bus.en = 1'b0;
      step();
      bus.en = 1'b1;
      step();
      bus.pd_valid = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         bus.pd_lead = (int'(bus.Q) <= target);
         step();
         done = !bus.busy;
      end
      bus.pd_valid = 1'b0;
      if (!done) timeout("sar_done");
   endtask

   task automatic lock_up(output int nd);
      bit d;
      d  = 0;
      nd = 0;
      while (!bus.lock && nd < 40) begin
         decide(d);
         d = !d;
         nd++;
      end
   endtask

   typedef struct {
      logic          r, e, v, l;
      logic [CW-1:0] q;
      logic [FW-1:0] t;
      logic          bz;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nd;
      logic [CW-1:0] qs;
      logic [FW-1:0] ts;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 16'h00FF, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd32, 16'h00FF, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd32, 16'h00FF, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd32, 16'h00FF, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd32, 16'h00FF, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  16'h00FF, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd16, 16'h00FF, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd16, 16'h00FF, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd16, 16'h00FF, 1'b0};

      rst = 1'b1;
      bus.en = 1'b0;
      bus.pd_valid = 1'b0;
      bus.pd_lead = 1'b0;

      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].r;
         bus.en = tbl[i].e;
         bus.pd_valid = tbl[i].v;
         bus.pd_lead = tbl[i].l;
         step();
         check($sformatf("vec%0d_Q", i), bus.Q, tbl[i].q);
         check($sformatf("vec%0d_T", i), bus.T, tbl[i].t);
         check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].bz);
      end
      rst = 1'b0;
      bus.pd_valid = 1'b0;

      // Reset in the middle of a search
      bus.en = 1'b0;
      step();
      bus.en = 1'b1;
      step();
      bus.pd_valid = 1'b1;
      for (int k = 0; k < 100 && !(m_srch && m_q == 40); k++) begin
         bus.pd_lead = (int'(bus.Q) <= 45);
         step();
      end
      check("midsar_Q", bus.Q, 6'b101000);
      rst = 1'b1;
      step();
      check("rst_Q", bus.Q, 0);
      check("rst_T", bus.T, 16'h0000);
      check("rst_Tb", bus.Tb, 16'hFFFF);
      check("rst_lock", bus.lock, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;
      bus.pd_valid = 1'b0;

      // SAR convergence onto 45, then lock / unlock
      run_sar(45);
      check("sar_Q", bus.Q, 45);
      check("sar_T", bus.T, 16'h00FF);
      check("sar_busy", bus.busy, 0);
      lock_up(nd);
      check("lock_decisions", nd, 9);
      check("lock_set", bus.lock, 1);
      nd = 0;
      while (bus.lock && nd < 10) begin
         decide(1'b0);
         nd++;
      end
      check("unlock_lags", nd, 4);
      check("unlock_lock", bus.lock, 0);

      // Carry and borrow across a coarse step
      run_sar(10);
      check("carry_start_Q", bus.Q, 10);
      for (int i = 0; i < 8; i++) decide(1'b1);
      check("carry_pre_T", bus.T, 16'hFFFF);
      decide(1'b1);
      check("carry_Q", bus.Q, 11);
      check("carry_T", bus.T, 16'h0001);
      decide(1'b0);
      check("borrow_pre_T", bus.T, 16'h0000);
      decide(1'b0);
      check("borrow_Q", bus.Q, 10);
      check("borrow_T", bus.T, 16'h7FFF);

      // Saturation at the top, sticky until SAR re-entry
      run_sar(63);
      for (int i = 0; i < 8; i++) decide(1'b1);
      decide(1'b1);
      check("sat_hi_Q", bus.Q, 63);
      check("sat_hi_T", bus.T, 16'hFFFF);
      check("sat_hi_flag", bus.sat, 1);
      bus.en = 1'b0;
      step();
      check("sat_idle_flag", bus.sat, 1);
      bus.en = 1'b1;
      step();
      check("sat_clr_flag", bus.sat, 0);
      check("sat_clr_Q", bus.Q, 32);

      // Saturation at the bottom
      run_sar(-1);
      check("sat_lo_start_Q", bus.Q, 0);
      for (int i = 0; i < 8; i++) decide(1'b0);
      decide(1'b0);
      check("sat_lo_T", bus.T, 16'h0000);
      check("sat_lo_flag", bus.sat, 1);

      // en drop together with an acceptable pd_valid while locked
      run_sar(20);
      lock_up(nd);
      check("relock", bus.lock, 1);
      for (int k = 0; k < 20 && m_set != 0; k++) step();
      qs = bus.Q;
      ts = bus.T;
      bus.en = 1'b0;
      bus.pd_valid = 1'b1;
      bus.pd_lead = 1'b1;
      step();
      check("endrop_Q", bus.Q, qs);
      check("endrop_T", bus.T, ts);
      check("endrop_lock", bus.lock, 0);
      check("endrop_busy", bus.busy, 0);
      bus.en = 1'b1;
      bus.pd_valid = 1'b0;
      step();
      check("restart_Q", bus.Q, 6'b100000);
      check("restart_busy", bus.busy, 1);

      // Randomized traffic, mostly alternating so lock/unlock both occur
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         bus.en = ($urandom_range(0, 199) != 0);
         bus.pd_valid = ($urandom_range(0, 2) != 0);
         bus.pd_lead = ($urandom_range(0, 2) != 0) ? !m_pd : m_pd;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
